lfsr_checker: RTL
=================

# lfsr_checker

Consumes the 32-bit pseudo-random word stream produced by `lfsr_generator` and checks it for integrity. It self-synchronises to the incoming sequence without needing the generator seed. Once locked, it flywheels its own expected sequence and counts mismatching words. It sits directly downstream of the generator, at the receive end of a link or datapath under test.

## Interface
- `LOCK_WORDS`, 4: consecutive correctly predicted words needed in SYNC to declare lock (≥1).
- `LOSS_WORDS`, 3: consecutive mismatching words in LOCKED that drop lock (≥1).
- `CNT_WIDTH`, 32: width of the error, word and bit-error counters.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dv_in`  in  1  `datain` is valid this cycle.
- `datain`  in  32  received LFSR word.
- `clear`  in  1  synchronous clear of all counters; does not affect lock state.
- `locked`  out  1  checker is in LOCKED.
- `err_pulse`  out  1  one-cycle pulse for each mismatching word seen while LOCKED.
- `err_count`  out  CNT_WIDTH  saturating count of mismatched words.
- `word_count`  out  CNT_WIDTH  saturating count of valid words checked while LOCKED.
- `bit_err_count`  out  CNT_WIDTH  saturating count of mismatched bits (see Configuration).

## Operation
- Next-word function: the team's combinational `lfsr` module with WIDTH=32. This is the same step the generator uses.
- Registered state: `state`, `expected[31:0]`, `run` (match/miss run counter) and all counters.
- A cycle with `dv_in`=0 changes nothing except forcing `err_pulse`=0.
- **HUNT**
  - On `dv_in` with `datain`≠0: `expected` ← lfsr(`datain`), `run` ← 0, go to SYNC.
  - `datain`=0 is the LFSR lockup word: it is ignored and the checker stays in HUNT.
- **SYNC**, on `dv_in`:
  - Match (`datain`==`expected`): `expected` ← lfsr(`datain`), `run`++. If `run`+1==`LOCK_WORDS`, go to LOCKED with `run` ← 0.
  - Mismatch with `datain`≠0: reseed with `expected` ← lfsr(`datain`), `run` ← 0.
  - Mismatch with `datain`=0: go to HUNT.
  - No errors are counted in SYNC.
- **LOCKED**, on `dv_in`:
  - `expected` ← lfsr(`expected`) (flywheel; `datain` is never used to reseed).
  - `word_count`++.
  - Match: `run` ← 0.
  - Mismatch: `err_pulse`=1, `err_count`++, `bit_err_count` += popcount(`datain`^`expected`), `run`++. If `run`+1==`LOSS_WORDS`, go to HUNT with `run` ← 0.
- **Counters**
  - All counters saturate at 2^CNT_WIDTH−1 and never wrap.
  - `clear` zeroes every counter. If an increment occurs in the same cycle, the result equals that cycle's increment, so no event is lost.
- **Reset**
  - Reset values: `state`=HUNT, `expected`=0, `run`=0, `locked`=0, `err_pulse`=0, all counters 0.
  - Reset mid-operation discards lock immediately.

## Timing
- Every output is registered. A word presented with `dv_in` in cycle N affects the outputs in cycle N+1.
- Lock timing: the first accepted word seeds the checker; the next `LOCK_WORDS` matching valid words lead to `locked`=1. `locked` rises the cycle after the (`LOCK_WORDS`+1)th valid word, counting the seed word.
- `locked` falls the cycle after the `LOSS_WORDS`th consecutive bad word. That final bad word is still counted in `err_count` and `err_pulse`.
- Gaps in `dv_in` of any length are allowed. Miss runs are not broken by gaps, only by a matching word.
- Throughput is one word per cycle; there is no back-pressure.

## Configuration
- `LFSR_CHECKER_BITERR_EN`
  - Defined: the 32-bit XOR/popcount logic and the `bit_err_count` register are built, with the behaviour described in Operation.
  - Undefined: `bit_err_count` is tied to 0 and no popcount logic is synthesised.
  - All other behaviour is identical in both builds.

## Test plan
- Lock acquisition: after reset, drive 10 consecutive generator words from seed 1 with defaults. Required: `locked` goes to 1 the cycle after the 5th word; `word_count`=5 and `err_count`=0 at the end.
- Single-bit error: once locked, flip bit 0 of one word. Required: one `err_pulse` the next cycle, `err_count`=1, `bit_err_count`=1 (macro defined) or 0 (macro undefined), `locked` stays 1, and following clean words give no further errors.
- Loss of lock: once locked, send 3 consecutive words that are 0xFFFFFFFF XOR expected. Required: `err_count`=3, `bit_err_count`=96, `locked`=0 the cycle after the 3rd word; clean words then re-lock after 5 more words.
- Gaps and zero word: interleave `dv_in`=0 for 1 to 7 cycles between valid words, then send `datain`=0 while in HUNT. Required: lock timing counted only in valid words; HUNT is held on the zero word.
- Counter edges: set `CNT_WIDTH`=4 and inject 20 errors without exceeding the loss run. Required: `err_count` saturates at 15. Then assert `clear` in the same cycle as an error. Required: `err_count`=1.
- Reset mid-lock: assert `reset` for 1 cycle while locked. Required: all outputs 0 the next cycle; re-lock takes a full seed plus 4 matching words.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising integrity checker for a 32-bit LFSR word stream.
// Ports: clk; reset (sync, active-high); dv_in/datain (received word); clear (zero counters);
//        locked, err_pulse, err_count, word_count, bit_err_count (all registered).
// Optional feature macro: LFSR_CHECKER_BITERR_EN builds the popcount bit-error counter;
// without it bit_err_count is tied to zero.
module lfsr_checker #(
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dv_in,
    input  logic [31:0]          datain,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] bit_err_count
);

    localparam int RUN_MAX = (LOCK_WORDS > LOSS_WORDS) ? LOCK_WORDS : LOSS_WORDS;
    localparam int RW      = $clog2(RUN_MAX + 1);
    // Sum width wide enough for counter plus a 6-bit popcount without overflow.
    localparam int SW      = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_e;

    state_e               state_q;
    logic [31:0]          exp_q;
    logic [RW-1:0]        run_q;
    logic                 locked_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    logic          match;
    logic          word_inc;
    logic          err_inc;
    logic [RW-1:0] run_inc;

    // Fibonacci step, polynomial x^32 + x^22 + x^2 + x + 1 (shared with the generator).
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [5:0]           inc
    );
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(inc);
        if (sum > SW'(CNT_MAX)) return CNT_MAX;
        return sum[CNT_WIDTH-1:0];
    endfunction

    assign match    = (datain == exp_q);
    assign word_inc = dv_in && (state_q == LOCKED);
    assign err_inc  = word_inc && !match;
    assign run_inc  = run_q + RW'(1);

    // Clear and increment in the same cycle keep the increment.
    always_comb begin
        err_cnt_d  = sat_add(clear ? '0 : err_cnt_q, {5'd0, err_inc});
        word_cnt_d = sat_add(clear ? '0 : word_cnt_q, {5'd0, word_inc});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (dv_in) begin
                unique case (state_q)
                    HUNT: begin
                        // Zero is the lockup word and can never seed.
                        if (datain != '0) begin
                            exp_q   <= lfsr_step(datain);
                            run_q   <= '0;
                            state_q <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (match) begin
                            exp_q <= lfsr_step(datain);
                            if (run_inc == RW'(LOCK_WORDS)) begin
                                run_q    <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else if (datain != '0) begin
                            exp_q <= lfsr_step(datain);
                            run_q <= '0;
                        end else begin
                            run_q   <= '0;
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the received word never reseeds once locked.
                        exp_q <= lfsr_step(exp_q);
                        if (match) begin
                            run_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                            if (run_inc == RW'(LOSS_WORDS)) begin
                                run_q    <= '0;
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end
                    end
                    default: begin
                        run_q   <= '0;
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

`ifdef LFSR_CHECKER_BITERR_EN
    logic [31:0]          diff;
    logic [5:0]           pop;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

    assign diff = datain ^ exp_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) pop = pop + {5'd0, diff[i]};
        bit_cnt_d = sat_add(clear ? '0 : bit_cnt_q, err_inc ? pop : 6'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) bit_cnt_q <= '0;
        else       bit_cnt_q <= bit_cnt_d;
    end

    assign bit_err_count = bit_cnt_q;
`else
    assign bit_err_count = '0;
`endif

    assign locked     = locked_q;
    assign err_pulse  = err_q;
    assign err_count  = err_cnt_q;
    assign word_count = word_cnt_q;

endmodule
